// File: rtl/approx_mul_seq_if.sv
// ---------------------------------------------------------------------------
// approx_mul_seq_if
// Handshake bundle for the iterative approximate/exact signed multiplier.
//
// Handshake rules (both directions): a transfer happens on a rising clk edge
// where valid && ready are both 1. The producer holds valid and its payload
// stable until that edge. ready may depend on state but never on the same
// side's valid.
//
// Signals:
//   in_valid   master->slave  operands and mode are valid
//   in_ready   slave->master  multiplier can accept an operation
//   in_a       master->slave  multiplicand, two's complement, WIDTH bits
//   in_b       master->slave  multiplier, two's complement, WIDTH bits
//   in_approx  master->slave  1 = approximate (LSB-truncated) mode
//   out_valid  slave->master  result is available
//   out_ready  master->slave  consumer accepts the result
//   out_result slave->master  signed product, 2*WIDTH bits
//   out_approx slave->master  mode captured with this operation
// ---------------------------------------------------------------------------
interface approx_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               in_approx;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_result;
    logic               out_approx;

    modport master (
        output in_valid, in_a, in_b, in_approx, out_ready,
        input  in_ready, out_valid, out_result, out_approx
    );

    modport slave (
        input  in_valid, in_a, in_b, in_approx, out_ready,
        output in_ready, out_valid, out_result, out_approx
    );
endinterface

// File: rtl/approx_mul_seq.sv
// ---------------------------------------------------------------------------
// approx_mul_seq
// Iterative signed multiplier, one 4-bit digit of the multiplier per cycle,
// with a run-time exact/approximate mode. Approximate mode zeroes the
// APPROX_LSB low bits of both operands when they are captured.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   bus          approx_mul_seq_if.slave (in_* request side, out_* result side)
//   dbg_state_o  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Timing: accept at edge T, out_valid rises after edge T+N (N = WIDTH/4),
// or after edge T+1 when either masked operand is zero.
// ---------------------------------------------------------------------------
module approx_mul_seq #(
    parameter int WIDTH      = 8,
    parameter int APPROX_LSB = 3
) (
    input  logic            clk,
    input  logic            reset,
    approx_mul_seq_if.slave bus,
    output logic [1:0]      dbg_state_o
);
    localparam int N  = WIDTH / 4;
    localparam int PW = 2 * WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [WIDTH-1:0] KEEP_MASK  = {WIDTH{1'b1}} << APPROX_LSB;
    localparam logic [CW-1:0]    LAST_DIGIT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   a_q, a_d;      // sign-extended multiplicand, pre-shifted by 4*i
    logic [WIDTH-1:0] b_q, b_d;     // multiplier, shifted right so [3:0] is digit i
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   res_q, res_d;
    logic            apx_q, apx_d;
    logic            valid_q, valid_d;

    // Operand masking applies only to what gets captured.
    logic [WIDTH-1:0] a_in_m, b_in_m;
    assign a_in_m = bus.in_approx ? (bus.in_a & KEEP_MASK) : bus.in_a;
    assign b_in_m = bus.in_approx ? (bus.in_b & KEEP_MASK) : bus.in_b;

    // Four partial-product rows for the current digit. On the top digit bit 3
    // carries weight -8, so its row is subtracted instead of added.
    logic          last_digit;
    logic [PW-1:0] row0, row1, row2, row3;
    logic [PW-1:0] pp, acc_sum;

    assign last_digit = (cnt_q == LAST_DIGIT);
    assign row0 = b_q[0] ? a_q          : '0;
    assign row1 = b_q[1] ? (a_q << 1)   : '0;
    assign row2 = b_q[2] ? (a_q << 2)   : '0;
    assign row3 = b_q[3] ? (a_q << 3)   : '0;
    assign pp      = last_digit ? (row0 + row1 + row2 - row3)
                                : (row0 + row1 + row2 + row3);
    assign acc_sum = acc_q + pp;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        apx_d   = apx_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = {{WIDTH{a_in_m[WIDTH-1]}}, a_in_m};
                    b_d     = b_in_m;
                    apx_d   = bus.in_approx;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Zero operand short-circuits on the first RUN cycle.
                if (cnt_q == '0 && (a_q == '0 || b_q == '0)) begin
                    res_d   = '0;
                    state_d = S_DONE;
                end else begin
                    acc_d = acc_sum;
                    a_d   = a_q << 4;
                    b_d   = b_q >> 4;
                    if (last_digit) begin
                        res_d   = acc_sum;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            apx_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            apx_q   <= apx_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE) && !reset;
    assign bus.out_valid  = valid_q;
    assign bus.out_result = res_q;
    assign bus.out_approx = apx_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_approx_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_approx_mul_seq
// Three multiplier instances (WIDTH 8/16/32); one is active at a time via sel.
// The driver pushes expected {mode, latency, product} into exp_q; a monitor
// pops and compares whenever the active instance presents out_valid.
// ---------------------------------------------------------------------------
module tb_approx_mul_seq;
    localparam int LSB8  = 3;
    localparam int LSB16 = 5;
    localparam int LSB32 = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    approx_mul_seq_if #(.WIDTH(8))  if8 ();
    approx_mul_seq_if #(.WIDTH(16)) if16 ();
    approx_mul_seq_if #(.WIDTH(32)) if32 ();
    logic [1:0] st8, st16, st32;

    approx_mul_seq #(.WIDTH(8),  .APPROX_LSB(LSB8))  dut8  (.clk(clk), .reset(reset), .bus(if8),  .dbg_state_o(st8));
    approx_mul_seq #(.WIDTH(16), .APPROX_LSB(LSB16)) dut16 (.clk(clk), .reset(reset), .bus(if16), .dbg_state_o(st16));
    approx_mul_seq #(.WIDTH(32), .APPROX_LSB(LSB32)) dut32 (.clk(clk), .reset(reset), .bus(if32), .dbg_state_o(st32));

    int          sel = 0;
    int          cur_w = 8;
    int          cur_lsb = LSB8;
    logic        drv_valid = 1'b0;
    logic        drv_approx = 1'b0;
    logic        drv_out_ready = 1'b1;
    logic [31:0] drv_a = '0;
    logic [31:0] drv_b = '0;
    int          rdy_mode = 0;   // 0 always ready, 1 random, 2 stalled

    assign if8.in_valid   = drv_valid && (sel == 0);
    assign if8.in_a       = drv_a[7:0];
    assign if8.in_b       = drv_b[7:0];
    assign if8.in_approx  = drv_approx;
    assign if8.out_ready  = drv_out_ready;
    assign if16.in_valid  = drv_valid && (sel == 1);
    assign if16.in_a      = drv_a[15:0];
    assign if16.in_b      = drv_b[15:0];
    assign if16.in_approx = drv_approx;
    assign if16.out_ready = drv_out_ready;
    assign if32.in_valid  = drv_valid && (sel == 2);
    assign if32.in_a      = drv_a;
    assign if32.in_b      = drv_b;
    assign if32.in_approx = drv_approx;
    assign if32.out_ready = drv_out_ready;

    logic        cur_in_ready, cur_out_valid, cur_out_approx;
    logic [63:0] cur_out_result;
    always_comb begin
        cur_in_ready   = if8.in_ready;
        cur_out_valid  = if8.out_valid;
        cur_out_result = {48'b0, if8.out_result};
        cur_out_approx = if8.out_approx;
        if (sel == 1) begin
            cur_in_ready   = if16.in_ready;
            cur_out_valid  = if16.out_valid;
            cur_out_result = {32'b0, if16.out_result};
            cur_out_approx = if16.out_approx;
        end else if (sel == 2) begin
            cur_in_ready   = if32.in_ready;
            cur_out_valid  = if32.out_valid;
            cur_out_result = if32.out_result;
            cur_out_approx = if32.out_approx;
        end
    end

    // ---------------- scoreboard state ----------------
    logic [72:0] exp_q[$];   // {approx, latency[7:0], product[63:0]}
    int          acc_q[$];   // accept edge index per operation
    int          checks = 0;
    int          fails = 0;
    int          last_hs = 0;
    int          last_accept = 0;
    int          accept_prev_hs = 0;
    bit          holding = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: signed product of the (optionally masked) operands, taken
    // modulo 2^(2w). Zero flag marks the fast path.
    function automatic logic [63:0] ref_mul(input int w, input int lsb, input logic [31:0] a,
                                            input logic [31:0] b, input logic apx, output bit zero);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        sa = (sa <<< (64 - w)) >>> (64 - w);
        sb = (sb <<< (64 - w)) >>> (64 - w);
        if (apx) begin
            sa = sa & ~((longint'(1) << lsb) - 1);
            sb = sb & ~((longint'(1) << lsb) - 1);
        end
        zero = (sa == 0) || (sb == 0);
        p = sa * sb;
        if (w < 32) p = p & ((longint'(1) << (2 * w)) - 1);
        return p;
    endfunction

    function automatic logic [31:0] rand_op(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0:       v = 32'h0;
            1:       v = 32'h1 << (w - 1);
            2:       v = 32'hFFFF_FFFF;
            3:       v = $urandom_range(0, 15);
            4:       v = 32'h0 - $urandom_range(1, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // ---------------- driver ----------------
    // Entered and left at posedge+1.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic apx,
                         input logic [63:0] exp_r, input int exp_lat);
        bit accepted;
        accepted   = 0;
        drv_a      = a;
        drv_b      = b;
        drv_approx = apx;
        drv_valid  = 1'b1;
        for (int k = 0; k < 300 && !accepted; k++) begin
            @(negedge clk);
            if (cur_in_ready) begin
                exp_q.push_back({apx, 8'(exp_lat), exp_r});
                acc_q.push_back(cyc + 1);
                last_accept    = cyc + 1;
                accept_prev_hs = last_hs;
                accepted       = 1;
            end
        end
        if (!accepted) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout actual=no_accept required=accept (cycle %0d)", cyc);
        end
        @(posedge clk);
        #1;
        drv_valid  = 1'b0;
        drv_a      = $urandom;
        drv_b      = $urandom;
        drv_approx = 1'($urandom_range(0, 1));
    endtask

    task automatic issue_model(input logic [31:0] a, input logic [31:0] b, input logic apx);
        bit          zero;
        logic [63:0] r;
        r = ref_mul(cur_w, cur_lsb, a, b, apx, zero);
        issue(a, b, apx, r, zero ? 1 : cur_w / 4);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || holding) && k < 3000) begin
            @(posedge clk);
            k++;
        end
        if (k >= 3000) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic select_dut(input int s);
        sel     = s;
        cur_w   = (s == 0) ? 8 : (s == 1) ? 16 : 32;
        cur_lsb = (s == 0) ? LSB8 : (s == 1) ? LSB16 : LSB32;
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            issue_model(rand_op(cur_w), rand_op(cur_w), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       drv_out_ready = 1'b1;
                1:       drv_out_ready = 1'($urandom_range(0, 1));
                default: drv_out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [72:0] e;
        logic [72:0] held_e;
        int          t;
        held_e = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                holding = 0;
            end else if (cur_out_valid) begin
                chk("in_ready_while_busy", cur_in_ready, 0);
                if (!holding) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_result actual=0x%0h required=no_result", cur_out_result);
                    end else begin
                        e = exp_q.pop_front();
                        t = acc_q.pop_front();
                        held_e = e;
                        chk("result", cur_out_result, e[63:0]);
                        chk("out_approx", cur_out_approx, e[72]);
                        chk("latency", cyc - t, e[71:64]);
                    end
                    holding = 1;
                end else begin
                    chk("result_stable", cur_out_result, held_e[63:0]);
                    chk("approx_stable", cur_out_approx, held_e[72]);
                end
                if (drv_out_ready) begin
                    holding = 0;
                    last_hs = cyc + 1;
                end
            end else if (holding) begin
                chk("valid_dropped", cur_out_valid, 1);
                holding = 0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        checks++;
        fails++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    // ---------------- test sequence ----------------
    initial begin
        int k;
        select_dut(0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready8", if8.in_ready, 0);
        chk("reset_in_ready32", if32.in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid8", if8.out_valid, 0);
        chk("rst_out_result8", if8.out_result, 0);
        chk("rst_out_approx8", if8.out_approx, 0);
        chk("rst_in_ready8", if8.in_ready, 1);
        chk("rst_out_valid16", if16.out_valid, 0);
        chk("rst_in_ready16", if16.in_ready, 1);
        chk("rst_out_result32", if32.out_result, 0);
        @(posedge clk);
        #1;

        // WIDTH=8 directed cases with hand-derived results
        issue(32'h80, 32'h80, 1'b0, 64'h4000, 2);
        issue(32'hFF, 32'h7F, 1'b1, 64'hFC40, 2);
        issue(32'hFF, 32'h7F, 1'b0, 64'hFF81, 2);
        issue(32'h07, 32'h09, 1'b1, 64'h0000, 1);
        issue(32'h00, 32'h5A, 1'b0, 64'h0000, 1);
        drain();

        // Backpressure with a second operation waiting on in_valid
        rdy_mode = 2;
        issue(32'h12, 32'h34, 1'b0, 64'h03A8, 2);
        fork
            issue(32'h85, 32'h13, 1'b1, 64'hF800, 2);
            begin
                k = 0;
                while (!cur_out_valid && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                chk("bp_valid_seen", cur_out_valid, 1);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", cur_in_ready, 0);
                end
                rdy_mode = 0;
            end
        join
        chk("bp_turnaround", last_accept, accept_prev_hs + 1);
        drain();

        rdy_mode = 1;
        run_random(200);
        rdy_mode = 0;
        drain();

        // WIDTH=16: reset in the middle of an operation
        select_dut(1);
        issue(32'h1234, 32'h0101, 1'b0, 64'h0012_4634, 4);
        issue(32'h8000, 32'h8000, 1'b0, 64'h4000_0000, 4);
        drain();
        issue(32'h0321, 32'h0456, 1'b0, 64'h0, 4);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_in_ready", cur_in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        chk("abort_out_valid", cur_out_valid, 0);
        chk("abort_out_result", cur_out_result, 0);
        chk("abort_in_ready", cur_in_ready, 1);
        @(posedge clk);
        #1;
        issue(32'h0003, 32'hFFFB, 1'b0, 64'hFFFF_FFF1, 4);
        drain();

        rdy_mode = 1;
        run_random(1500);
        rdy_mode = 0;
        drain();

        // WIDTH=32
        select_dut(2);
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 8);
        issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 64'hC000_0000_8000_0000, 8);
        rdy_mode = 1;
        run_random(1500);
        rdy_mode = 0;
        drain();

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
